// File: rtl/activation_pkg.sv
// Shared types and default widths for the activation datapath.
// Lane and top-level parameters default to these constants so both stay in step.
package activation_pkg;

   typedef enum logic [1:0] {
      ACT_RELU  = 2'd0,
      ACT_LEAKY = 2'd1,
      ACT_IDENT = 2'd2,
      ACT_RSVD  = 2'd3
   } act_mode_e;

   localparam int ACT_DATA_WIDTH       = 16;
   localparam int ACT_WEIGHT_INT_WIDTH = 4;
   localparam int ACT_LANES            = 4;
   localparam int ACT_LEAK_SHIFT       = 3;

endpackage

// File: rtl/activation_unit_act_lane.sv
// One activation lane: a double-width signed product in, a requantized sample and a
// saturation flag out. Purely combinational.
module act_lane
   import activation_pkg::*;
#(
   parameter int DATA_WIDTH       = ACT_DATA_WIDTH,
   parameter int WEIGHT_INT_WIDTH = ACT_WEIGHT_INT_WIDTH,
   parameter int LEAK_SHIFT       = ACT_LEAK_SHIFT
) (
   input  act_mode_e                      mode_i,
   input  logic signed [2*DATA_WIDTH-1:0] prod_i,
   output logic        [DATA_WIDTH-1:0]   sample_o,
   output logic                           sat_o
);

   localparam int PW  = 2*DATA_WIDTH;
   localparam int TOP = PW-1-WEIGHT_INT_WIDTH;

   // Returns {saturated, sample}; the slice is in range only when the dropped integer
   // bits are all copies of the sign bit.
   function automatic logic [DATA_WIDTH:0] requant(input logic signed [PW-1:0] y);
      logic [WEIGHT_INT_WIDTH:0] hdr;
      hdr = y[PW-1 -: WEIGHT_INT_WIDTH+1];
      if (hdr == '0 || hdr == '1) begin
         return {1'b0, y[TOP -: DATA_WIDTH]};
      end else if (!y[PW-1]) begin
         return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
      end
   endfunction

   logic [DATA_WIDTH:0] res;

   always_comb begin
      res = '0;
      case (mode_i)
         ACT_LEAKY: res = prod_i[PW-1] ? requant(prod_i >>> LEAK_SHIFT) : requant(prod_i);
         ACT_IDENT: res = requant(prod_i);
         default:   res = prod_i[PW-1] ? '0 : requant(prod_i);
      endcase
   end

   assign sample_o = res[DATA_WIDTH-1:0];
   assign sat_o    = res[DATA_WIDTH];

endmodule

// File: rtl/activation_unit.sv
// Two-stage activation pipeline with valid/ready handshake and a sticky
// saturation-event counter covering all lanes.
module activation_unit
   import activation_pkg::*;
#(
   parameter int DATA_WIDTH       = ACT_DATA_WIDTH,
   parameter int WEIGHT_INT_WIDTH = ACT_WEIGHT_INT_WIDTH,
   parameter int LANES            = ACT_LANES,
   parameter int LEAK_SHIFT       = ACT_LEAK_SHIFT
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [LANES*2*DATA_WIDTH-1:0]   in_data,
   input  logic [1:0]                      in_mode,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [LANES*DATA_WIDTH-1:0]     out_data,
   input  logic                            sat_clr,
   output logic [15:0]                     sat_count
);

   localparam int PW = 2*DATA_WIDTH;

   logic                        vld_p1_q;
   logic [LANES*PW-1:0]         data_p1_q;
   act_mode_e                   mode_p1_q;
   logic                        vld_p2_q;
   logic [LANES*DATA_WIDTH-1:0] data_p2_q;
   logic [LANES*DATA_WIDTH-1:0] data_p2_d;
   logic [LANES-1:0]            sat_lane;
   logic [16:0]                 sat_beat;
   logic [16:0]                 sat_sum;
   logic [15:0]                 cnt_q;
   logic [15:0]                 cnt_d;
   logic                        ld_p2;

   assign in_ready = !vld_p1_q || !vld_p2_q || out_ready;
   assign ld_p2    = !vld_p2_q || out_ready;

   // Stage 1: capture products and the mode that travels with them
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1_q  <= 1'b0;
         data_p1_q <= '0;
         mode_p1_q <= ACT_RELU;
      end else if (in_ready) begin
         vld_p1_q <= in_valid;
         if (in_valid) begin
            data_p1_q <= in_data;
            mode_p1_q <= act_mode_e'(in_mode);
         end
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      act_lane #(
         .DATA_WIDTH       (DATA_WIDTH),
         .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
         .LEAK_SHIFT       (LEAK_SHIFT)
      ) u_lane (
         .mode_i   (mode_p1_q),
         .prod_i   (data_p1_q[l*PW +: PW]),
         .sample_o (data_p2_d[l*DATA_WIDTH +: DATA_WIDTH]),
         .sat_o    (sat_lane[l])
      );
   end

   always_comb begin
      sat_beat = '0;
      for (int l = 0; l < LANES; l++) begin
         sat_beat = sat_beat + 17'(sat_lane[l]);
      end
      sat_sum = {1'b0, cnt_q} + sat_beat;
      cnt_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end

   // Stage 2: activated samples; saturation events are counted as the beat lands here
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p2_q  <= 1'b0;
         data_p2_q <= '0;
      end else if (ld_p2) begin
         vld_p2_q <= vld_p1_q;
         if (vld_p1_q) begin
            data_p2_q <= data_p2_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || sat_clr) begin
         cnt_q <= '0;
      end else if (ld_p2 && vld_p1_q) begin
         cnt_q <= cnt_d;
      end
   end

   assign out_valid = vld_p2_q;
   assign out_data  = data_p2_q;
   assign sat_count = cnt_q;

endmodule

// File: tb/tb_activation_unit.sv
// Bench for activation_unit: directed corner beats plus randomized traffic scored
// against an arithmetic lane model.
module tb_activation_unit;

   localparam int DW   = 16;
   localparam int WI   = 4;
   localparam int LN   = 4;
   localparam int LS   = 3;
   localparam int PW   = 2*DW;
   localparam int FRAC = DW - WI;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [LN*PW-1:0]  in_data = '0;
   logic [1:0]        in_mode = 2'd0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [LN*DW-1:0]  out_data;
   logic              sat_clr = 1'b0;
   logic [15:0]       sat_count;

   int                n_checks = 0;
   int                n_fail = 0;
   logic [LN*DW-1:0]  exp_q[$];
   longint            sat_sum = 0;

   always #5 clk = ~clk;

   activation_unit #(
      .DATA_WIDTH       (DW),
      .WEIGHT_INT_WIDTH (WI),
      .LANES            (LN),
      .LEAK_SHIFT       (LS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Lane reference: scale by 2^-FRAC with floor, clamp to the signed output range.
   function automatic logic [DW:0] ref_lane(input logic [1:0] mode, input logic [PW-1:0] xb);
      longint x, q, maxv, minv;
      logic [DW:0] r;
      maxv = (longint'(1) << (DW-1)) - 1;
      minv = -(longint'(1) << (DW-1));
      x = longint'($signed(xb));
      if (x < 0 && mode == 2'd1) x = x >>> LS;
      q = x >>> FRAC;
      if (x < 0 && (mode == 2'd0 || mode == 2'd3)) r = '0;
      else if (q > maxv) r = {1'b1, 1'b0, {(DW-1){1'b1}}};
      else if (q < minv) r = {1'b1, 1'b1, {(DW-1){1'b0}}};
      else r = {1'b0, q[DW-1:0]};
      return r;
   endfunction

   function automatic logic [PW-1:0] rand_x();
      logic [PW-1:0] r, v;
      r = $urandom();
      case ($urandom_range(0, 3))
         0: v = r;
         1: v = {{(PW-FRAC-DW){r[FRAC+DW-1]}}, r[FRAC+DW-1:0]};
         2: case ($urandom_range(0, 7))
               0: v = 32'h07FFFFFF;
               1: v = 32'h08000000;
               2: v = 32'hF8000000;
               3: v = 32'hF7FFFFFF;
               4: v = 32'h80000000;
               5: v = 32'h7FFFFFFF;
               6: v = 32'hBFFFFFF8;
               default: v = 32'hC0000000;
            endcase
         default: v = {{(PW-20){r[19]}}, r[19:0]};
      endcase
      return v;
   endfunction

   function automatic logic [LN*PW-1:0] rand_beat();
      logic [LN*PW-1:0] b;
      for (int l = 0; l < LN; l++) b[l*PW +: PW] = rand_x();
      return b;
   endfunction

   function automatic logic [63:0] cnt_exp();
      return (sat_sum > 65535) ? 64'hFFFF : 64'(sat_sum);
   endfunction

   // Scoreboard: sampled on the falling edge, where handshakes for the next rising edge are settled
   initial begin
      logic [LN*DW-1:0] held, ev;
      logic [DW:0]      lr;
      bit               held_v;
      held_v = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            sat_sum = 0;
            held_v = 1'b0;
         end else begin
            if (held_v && out_valid) check_eq("stall_hold", out_data, held);
            held_v = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) check_eq("unexpected_out", {63'b0, out_valid}, 64'd0);
               else check_eq("out_data", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
               for (int l = 0; l < LN; l++) begin
                  lr = ref_lane(in_mode, in_data[l*PW +: PW]);
                  ev[l*DW +: DW] = lr[DW-1:0];
                  sat_sum += longint'(lr[DW]);
               end
               exp_q.push_back(ev);
            end
         end
      end
   end

   task automatic drive_beat(input logic [1:0] mode, input logic [LN*PW-1:0] d);
      bit acc;
      int guard;
      in_valid = 1'b1;
      in_mode = mode;
      in_data = d;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 1000) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!acc) check_eq("accept_timeout", {63'b0, in_ready}, 64'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check_eq("drain_queue", exp_q.size(), 0);
      check_eq("drain_idle", {63'b0, out_valid}, 64'd0);
   endtask

   task automatic clear_count();
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      sat_sum = 0;
      check_eq("clr_count", sat_count, 0);
   endtask

   task automatic directed(input string tag, input logic [1:0] mode, input logic [PW-1:0] x,
                           input logic [DW-1:0] exp_v, input logic [15:0] exp_cnt);
      drive_beat(mode, {{((LN-1)*PW){1'b0}}, x});
      in_valid = 1'b0;
      check_eq({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
      @(posedge clk);
      #1;
      check_eq({tag, "_lat2"}, {63'b0, out_valid}, 64'd1);
      check_eq({tag, "_data"}, out_data[DW-1:0], exp_v);
      check_eq({tag, "_cnt"}, sat_count, exp_cnt);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit acc;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check_eq("rst_out_data", out_data, 64'd0);
      check_eq("rst_sat_count", sat_count, 0);
      rst_n = 1'b1;
      check_eq("rst_in_ready", {63'b0, in_ready}, 64'd1);

      directed("relu_small", 2'd0, 32'h00001000, 16'h0001, 16'd0);
      directed("relu_sat",   2'd0, 32'h08000000, 16'h7FFF, 16'd1);
      directed("relu_neg",   2'd0, 32'hFFFFF000, 16'h0000, 16'd1);
      directed("leaky_neg",  2'd1, 32'hFFFFF000, 16'hFFFF, 16'd1);
      directed("ident_neg",  2'd2, 32'hFFFFF000, 16'hFFFF, 16'd1);
      directed("ident_min",  2'd2, 32'h80000000, 16'h8000, 16'd2);

      clear_count();
      acc = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_mode = 2'($urandom_range(0, 3));
            in_data = rand_beat();
         end
      end
      drain();
      check_eq("rand_cnt", sat_count, cnt_exp());

      for (int i = 0; i < 12; i++) drive_beat(2'(i % 4), rand_beat());
      drain();

      out_ready = 1'b0;
      fork
         begin
            for (int b = 0; b < 5; b++) drive_beat(2'(b % 3), rand_beat());
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
            check_eq("bp_out_valid", {63'b0, out_valid}, 64'd1);
            out_ready = 1'b1;
         end
      join
      drain();

      clear_count();
      for (int i = 0; i < 16383; i++) drive_beat(2'd2, {LN{32'h08000000}});
      drain();
      check_eq("cnt_fffc", sat_count, 16'hFFFC);
      drive_beat(2'd2, {LN{32'h08000000}});
      drain();
      check_eq("cnt_clamp", sat_count, 16'hFFFF);
      drive_beat(2'd0, {LN{32'h7FFFFFFF}});
      drain();
      check_eq("cnt_sticky", sat_count, cnt_exp());

      clear_count();
      drive_beat(2'd2, {LN{32'h80000000}});
      in_valid = 1'b0;
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      sat_sum = 0;
      check_eq("clr_wins", sat_count, 0);
      drain();
      check_eq("clr_wins_after", sat_count, 0);

      out_ready = 1'b0;
      drive_beat(2'd2, {LN{32'h08000000}});
      drive_beat(2'd2, {LN{32'h08000000}});
      in_valid = 1'b0;
      check_eq("full_in_ready", {63'b0, in_ready}, 64'd0);
      check_eq("full_cnt", sat_count, 16'd4);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
      check_eq("mid_rst_sat_count", sat_count, 0);
      check_eq("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
      check_eq("mid_rst_out_data", out_data, 64'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         check_eq("post_rst_idle", {63'b0, out_valid}, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
